alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
- Downstream stage of the ALU library units (subtractor, NAND, leading-ones counter, one-hot decoder); all four share the {o_y, o_overflow, o_err} result bundle.
- Buffers each accepted bundle in a small first-word-fall-through FIFO with a valid/ready handshake on both sides.
- Keeps sticky overflow/error status and a saturating error counter for the display/readout logic that consumes ALU results.

Parameters:
- WIDTH, 4: width of the result word y; must match the producing ALU unit.
- DEPTH, 4: number of FIFO entries; power of two, at least 2.
- CNT_W, 8: width of the saturating error counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_valid  input  1  upstream result bundle valid.
- o_ready  output  1  FIFO can accept a bundle.
- i_y  input  WIDTH  result word from ALU unit.
- i_overflow  input  1  overflow flag from ALU unit.
- i_err  input  1  error flag from ALU unit.
- o_valid  output  1  head entry valid (not empty).
- i_ready  input  1  downstream consumer accepts the head entry.
- o_y  output  WIDTH  head result word.
- o_overflow  output  1  head overflow flag.
- o_err  output  1  head error flag.
- o_count  output  $clog2(DEPTH)+1  current number of stored entries.
- o_full  output  1  count == DEPTH.
- o_empty  output  1  count == 0.
- i_clr_sticky  input  1  synchronous clear of sticky flags and error counter.
- o_sticky_ovf  output  1  an overflow was accepted since last clear/reset.
- o_sticky_err  output  1  an error was accepted since last clear/reset.
- o_err_cnt  output  CNT_W  accepted bundles with i_err=1, saturating.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, including mid-transfer):
  - Pointers = 0, count = 0; o_empty=1, o_full=0, o_valid=0.
  - o_y/o_overflow/o_err = 0; sticky flags = 0, o_err_cnt = 0.
  - Stored contents are discarded.
- Push = i_valid && o_ready. Pop = o_valid && i_ready. Both are evaluated on the rising edge.
- o_ready = !o_full, independent of i_ready. When full, a simultaneous pop does not enable a push in the same cycle.
- Storage: each entry holds {y, overflow, err} (WIDTH+2 bits) and is written at the write pointer on push. Pointers wrap modulo DEPTH.
- First-word fall-through: o_y, o_overflow and o_err show the entry at the read pointer whenever o_valid=1, and are forced to 0 when empty.
- Latency: a bundle pushed into an empty FIFO appears on o_valid/o_y in the cycle after the push edge. There is no combinational path from i_valid to o_valid.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together (possible only when 0<count<DEPTH): unchanged, both pointers advance.
- Pop when empty is impossible (o_valid=0). Push when full is ignored: data is not written and the upstream source must hold its bundle.
- Sticky flags:
  - Set on a push with i_overflow=1 (resp. i_err=1).
  - Cleared by i_clr_sticky.
  - If clear and set occur in the same cycle, set wins (flag=1).
- o_err_cnt:
  - Increments by 1 on a push with i_err=1 and saturates at 2^CNT_W−1.
  - i_clr_sticky loads 0, or loads 1 if a push with i_err=1 occurs in the same cycle.
- Flags and counter respond only to accepted pushes, never to ignored ones.
- o_full, o_empty and o_count are registered-state derived and consistent with o_valid in every cycle.

Test Plan:
- Reset then idle → o_empty=1, o_valid=0, o_ready=1, o_count=0, o_y=0, sticky=0, o_err_cnt=0.
- Push y=3, y=5, y=9, y=12 (ov=0, err=0) with i_ready=0 → o_count steps 1..4, o_full=1, o_ready=0. A fifth push of y=7 is ignored. Then i_ready=1 for 4 cycles → outputs 3,5,9,12 in order, then o_empty=1.
- Continuous push and pop with i_ready=1 and count held at 2, running 10 cycles across pointer wrap → o_count stays 2 and output order matches input order exactly.
- Push bundle {y=0, ov=1, err=0}, then {y=15, ov=0, err=1} → o_sticky_ovf=1, o_sticky_err=1, o_err_cnt=1. Assert i_clr_sticky in the same cycle as another err=1 push → o_sticky_err=1, o_sticky_ovf=0, o_err_cnt=1.
- With CNT_W=2, push 5 bundles with err=1 while popping → o_err_cnt counts 1,2,3,3,3 (saturates).
- Fill with 3 entries, assert i_rst mid-cycle asynchronously → outputs return to reset values immediately. After release, the first push of y=6 appears at the head one cycle later.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: FWFT buffer for ALU result bundles with sticky status and saturating error count
module alu_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH-1:0]           i_y,
  input  logic                       i_overflow,
  input  logic                       i_err,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_y,
  output logic                       o_overflow,
  output logic                       o_err,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty,
  input  logic                       i_clr_sticky,
  output logic                       o_sticky_ovf,
  output logic                       o_sticky_err,
  output logic [CNT_W-1:0]           o_err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH+1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic             r_sov, r_ser;
  logic [CNT_W-1:0] r_ecnt;
  logic             w_full, w_empty, w_push, w_pop, w_push_err;
  logic [WIDTH+1:0] w_head;
  assign w_full     = r_cnt == CW'(DEPTH);
  assign w_empty    = r_cnt == '0;
  assign w_push     = i_valid && !w_full;
  assign w_pop      = !w_empty && i_ready;
  assign w_push_err = w_push && i_err;
  assign w_head     = w_empty ? '0 : r_mem[r_rp];
  assign o_ready    = !w_full;
  assign o_valid    = !w_empty;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_cnt;
  assign o_y        = w_head[WIDTH+1:2];
  assign o_overflow = w_head[1];
  assign o_err      = w_head[0];
  assign o_sticky_ovf = r_sov;
  assign o_sticky_err = r_ser;
  assign o_err_cnt  = r_ecnt;
  // storage needs no reset: entries are unreachable until rewritten
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp] <= {i_y, i_overflow, i_err};
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_sov  <= 1'b0;
      r_ser  <= 1'b0;
      r_ecnt <= '0;
    end else begin
      r_wp   <= r_wp + AW'(w_push);
      r_rp   <= r_rp + AW'(w_pop);
      r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_sov  <= (r_sov && !i_clr_sticky) || (w_push && i_overflow);
      r_ser  <= (r_ser && !i_clr_sticky) || w_push_err;
      r_ecnt <= i_clr_sticky ? CNT_W'(w_push_err) :
                (w_push_err && !(&r_ecnt)) ? r_ecnt + 1'b1 : r_ecnt;
    end
  end
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: scoreboard bench for alu_result_fifo
module tb_alu_result_fifo;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic i_valid = 0, i_ready = 0, i_ov = 0, i_er = 0, i_clr = 0;
  logic [WIDTH-1:0] i_y = '0;
  logic o_ready, o_valid, o_ov, o_er, o_full, o_empty, o_sov, o_ser;
  logic [WIDTH-1:0] o_y;
  logic [$clog2(DEPTH):0] o_count;
  logic [CNT_W-1:0] o_ecnt;
  int total = 0, bad = 0;
  logic [WIDTH+1:0] q[$];
  logic m_sov = 0, m_ser = 0;
  int m_ecnt = 0;
  always #5 clk = ~clk;
  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_y(i_y), .i_overflow(i_ov), .i_err(i_er), .o_valid(o_valid),
    .i_ready(i_ready), .o_y(o_y), .o_overflow(o_ov), .o_err(o_er),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
    .i_clr_sticky(i_clr), .o_sticky_ovf(o_sov), .o_sticky_err(o_ser),
    .o_err_cnt(o_ecnt));
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic chk_state();
    chk("count", o_count, q.size());
    chk("valid", o_valid, q.size() != 0);
    chk("empty", o_empty, q.size() == 0);
    chk("full", o_full, q.size() == DEPTH);
    chk("ready", o_ready, q.size() != DEPTH);
    chk("sticky_ovf", o_sov, m_sov);
    chk("sticky_err", o_ser, m_ser);
    chk("err_cnt", o_ecnt, m_ecnt);
    if (q.size() == 0) chk("empty_head", {o_y, o_ov, o_er}, 0);
  endtask
  task automatic cyc(input logic v, input int y, input logic ov, input logic er,
                     input logic rdy, input logic clr);
    logic push, pop;
    logic [WIDTH+1:0] e;
    i_valid = v; i_y = WIDTH'(y); i_ov = ov; i_er = er; i_ready = rdy; i_clr = clr;
    chk_state();
    push = v && q.size() < DEPTH;
    pop = rdy && q.size() > 0;
    if (pop) begin
      e = q.pop_front();
      chk("head", {o_y, o_ov, o_er}, e);
    end
    @(posedge clk); #1;
    if (push) q.push_back({WIDTH'(y), ov, er});
    m_sov = (m_sov && !clr) || (push && ov);
    m_ser = (m_ser && !clr) || (push && er);
    m_ecnt = clr ? int'(push && er) :
             (push && er && m_ecnt < (1 << CNT_W) - 1) ? m_ecnt + 1 : m_ecnt;
    i_valid = 0; i_ready = 0; i_clr = 0; i_ov = 0; i_er = 0;
  endtask
  initial begin
    int ins[4] = '{3, 5, 9, 12};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_y", o_y, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    foreach (ins[i]) cyc(1, ins[i], 0, 0, 0, 0);
    chk("full_now", o_full, 1);
    cyc(1, 7, 0, 0, 0, 0);
    chk("full_ignored_cnt", o_count, 4);
    repeat (4) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 3 + i, 0, 0, 1, 0);
    chk("stream_cnt", o_count, 2);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 1, 0);
    cyc(1, 15, 0, 1, 1, 0);
    chk("sov_set", o_sov, 1);
    chk("ecnt_one", o_ecnt, 1);
    cyc(1, 4, 0, 1, 1, 1);
    chk("clr_set_wins", o_ser, 1);
    chk("clr_ovf", o_sov, 0);
    chk("clr_ecnt", o_ecnt, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, i, 0, 1, 1, 0);
    chk("ecnt_sat", o_ecnt, 3);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 8 + i, 1, 1, 0, 0);
    #3 rst = 1;
    #1;
    q.delete(); m_sov = 0; m_ser = 0; m_ecnt = 0;
    chk_state();
    chk("async_y", o_y, 0);
    @(posedge clk); #1;
    rst = 0;
    chk_state();
    cyc(1, 6, 0, 0, 0, 0);
    chk("post_rst_y", o_y, 6);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
